com_config_array_serializer: RTL and testbench
==============================================

# com_config_array_serializer

Downstream consumer of the SW-written configuration registers: on command, it shifts one 256×16 configuration array out to the pixel ASIC over a 3-wire serial interface (sclk/sdata/load) at a programmable rate. It captures the chip's serial return stream into a readback array for SW comparison. It sits between the config write-register block (which supplies `config_array_0/1` and `config_static_0`) and the chip I/O pads.

## Interface
Parameters:
- `DEPTH`, 256: number of words per array.
- `WORD_W`, 16: bits per word.

Ports:
- `fw_clk_100`  in  1  FW clock, 100 MHz.
- `fw_rst_n`  in  1  reset, asynchronous, active-low.
- `op_code_w_reset`  in  1  synchronous abort/clear pulse.
- `op_code_w_execute`  in  1  start pulse, one cycle.
- `array_sel`  in  1  0 = `config_array_0`, 1 = `config_array_1`; sampled at start.
- `clk_div`  in  8  half-period of sclk minus 1, in fw_clk cycles (`config_static_0[7:0]`); sampled at start.
- `config_array_0`, `config_array_1`  in  [DEPTH-1:0][WORD_W-1:0]  source arrays.
- `cfg_sdo`  in  1  serial return from chip, already synchronized to fw_clk.
- `cfg_sclk`  out  1  serial clock to chip.
- `cfg_sdata`  out  1  serial data to chip.
- `cfg_load`  out  1  latch strobe to chip.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `readback_array`  out  [DEPTH-1:0][WORD_W-1:0]  captured sdo words.

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT_LO: sclk=0, sdata driven.
  - SHIFT_HI: sclk=1.
  - LOAD: load strobe.
  - DONE: completion pulse.
- H = clk_div+1. An internal tick fires every H cycles while not IDLE. Every phase lasts exactly H cycles.
- IDLE → SHIFT_LO on `op_code_w_execute`. Captures `array_sel` and H, and clears the word index (8 b) and bit index (4 b).
- Bit order: word 0 first. Within a word, bit 15 (MSB) first. 4096 bits total.
- sdata changes only on entry to SHIFT_LO. The chip samples on the sclk rising edge.
- The source word is read from the live selected array on entry to its first bit (bit 15). SW writes to words not yet reached take effect; writes to the current or earlier words do not.
- sdo is sampled on the fw_clk edge that enters SHIFT_HI and shifted into a 16-bit register, MSB first. The completed word is written to `readback_array[word]` on the exit of that word's last SHIFT_HI.
- SHIFT_HI → SHIFT_LO (next bit) on tick. After bit 0 of word 255, SHIFT_HI → LOAD; the word and bit indices do not wrap further.
- LOAD: sclk=0, sdata=0, `cfg_load`=1 for 2H cycles. Then → DONE.
- DONE: `done`=1 for one cycle, `busy`=0. Then → IDLE.
- `op_code_w_execute` while busy: ignored.
- `op_code_w_reset` has priority over everything, in any state:
  - next cycle: IDLE, all serial outputs 0, `readback_array` cleared, no `done`.
  - If reset and execute coincide in IDLE: reset wins and no transfer starts.
- `clk_div` = 255 is legal (H = 256). `clk_div` = 0 gives a 50 MHz sclk.

## Timing
- Reset values: `cfg_sclk`, `cfg_sdata`, `cfg_load`, `busy`, `done` = 0; `readback_array` = all 0; state IDLE.
- The start pulse is at cycle T.
  - `busy`=1 and first sdata valid (sclk low) from T+1.
  - First sclk rise at T+1+H.
  - Bit n rises at T+1+H+2nH.
- `cfg_load` high from T+1+8192H to T+1+8194H-1.
- `done` pulse at T+1+8194H. `busy` is 0 in that same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `com_config_pkg`:
  - `DEPTH`, `WORD_W` localparams.
  - `ser_state_t` enum {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE}.
  - `cfg_word_t` typedef logic [WORD_W-1:0].
- Sub-module `com_config_sclk_tick`: 8-bit down-counter. Reload value `clk_div`, `enable` input, one-cycle `tick` output, synchronous clear. The serializer FSM, shift registers and readback store stay in the top module.

## Test plan
- Reset release, then idle 100 cycles → all outputs 0, `busy`=0, `readback_array` all 0.
- `config_array_0[0]`=16'hA5C3, others 0, `clk_div`=0, `array_sel`=0, execute; sdo looped back to sdata → first 16 sclk-rise samples of sdata = 1010_0101_1100_0011. `done` at T+1+8194. `readback_array[0]`=16'hA5C3, rest 0.
- `clk_div`=3, `array_sel`=1, `config_array_1[255]`=16'h8001 → sclk period 8 cycles. Last two bits are 0 then 1. `load` high 8 cycles. `done` at T+1+32776.
- Execute re-pulsed mid-transfer → ignored; exactly one `done`, timing unchanged.
- `op_code_w_reset` at bit 1000 → next cycle `busy`, `sclk`, `sdata`, `load` = 0, `readback_array` cleared, no `done`. A new execute starts cleanly from word 0.
- `clk_div`=255 transfer → sclk half-period 256 cycles, `done` at T+1+8194·256.

Source files
------------

// File: rtl/com_config_pkg.sv
// Shared types and sizes for the configuration-array serializer.
package com_config_pkg;

   localparam int DEPTH  = 256;
   localparam int WORD_W = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT_LO = 3'd1,
      SHIFT_HI = 3'd2,
      LOAD     = 3'd3,
      DONE     = 3'd4
   } ser_state_t;

   typedef logic [WORD_W-1:0] cfg_word_t;

endpackage

// File: rtl/com_config_sclk_tick.sv
// Phase timer: fires a one-cycle tick every (reload+1) enabled cycles.
// i_clr holds the counter at the reload value so the first phase after a
// start is full length.
module com_config_sclk_tick (
   input  logic       fw_clk_100,
   input  logic       fw_rst_n,
   input  logic       i_clr,
   input  logic       i_enable,
   input  logic [7:0] i_reload,
   output logic       o_tick
);

   logic [7:0] r_cnt;

   // Down-counter that reloads on expiry or clear.
   always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         r_cnt <= 8'd0;
      end else if (i_clr) begin
         r_cnt <= i_reload;
      end else if (i_enable) begin
         if (r_cnt == 8'd0) begin
            r_cnt <= i_reload;
         end else begin
            r_cnt <= r_cnt - 8'd1;
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_tick = i_enable & ~i_clr & (r_cnt == 8'd0);

endmodule

// File: rtl/com_config_array_serializer.sv
// Shifts one selected configuration array out over sclk/sdata/load, MSB of
// word 0 first, and stores the returned sdo stream into readback_array.
module com_config_array_serializer #(
   parameter int DEPTH  = com_config_pkg::DEPTH,
   parameter int WORD_W = com_config_pkg::WORD_W
) (
   input  logic                          fw_clk_100,
   input  logic                          fw_rst_n,
   input  logic                          op_code_w_reset,
   input  logic                          op_code_w_execute,
   input  logic                          array_sel,
   input  logic [7:0]                    clk_div,
   input  logic [DEPTH-1:0][WORD_W-1:0]  config_array_0,
   input  logic [DEPTH-1:0][WORD_W-1:0]  config_array_1,
   input  logic                          cfg_sdo,
   output logic                          cfg_sclk,
   output logic                          cfg_sdata,
   output logic                          cfg_load,
   output logic                          busy,
   output logic                          done,
   output logic [DEPTH-1:0][WORD_W-1:0]  readback_array
);

   import com_config_pkg::*;

   localparam int IDX_W = $clog2(DEPTH);
   localparam int BIT_W = $clog2(WORD_W);
   localparam logic [BIT_W-1:0] MSB_POS  = BIT_W'(WORD_W - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   ser_state_t r_state;
   ser_state_t w_run_nxt;
   ser_state_t w_state_nxt;
   logic       w_run_start;
   logic       w_run_adv;
   logic       w_start;
   logic       w_advance;
   logic       w_srst;

   logic                    r_sel;
   logic [7:0]              r_clk_div;
   logic [IDX_W-1:0]        r_word_idx;
   logic [BIT_W-1:0]        r_bit_idx;
   logic                    r_load_half;
   logic [WORD_W-1:0]       r_tx_word;
   logic [WORD_W-1:0]       r_rx_word;
   logic [DEPTH-1:0][WORD_W-1:0] r_readback;

   logic r_sclk;
   logic r_sdata;
   logic r_load;
   logic r_busy;
   logic r_done;

   logic              w_tick;
   logic              w_tick_clr;
   logic              w_tick_en;
   logic [7:0]        w_reload;
   logic              w_last_bit;
   logic              w_entry_lo;
   logic [IDX_W-1:0]  w_word_nxt;
   logic [BIT_W-1:0]  w_bit_nxt;
   logic              w_sel_eff;
   logic [WORD_W-1:0] w_src_word;
   logic [WORD_W-1:0] w_tx_nxt;
   logic              w_sdata_nxt;

   assign w_srst     = op_code_w_reset;
   // While idle the timer tracks the live divider so it is preloaded at start.
   assign w_tick_clr = (r_state == IDLE) | w_srst;
   assign w_tick_en  = (r_state != IDLE);
   assign w_reload   = (r_state == IDLE) ? clk_div : r_clk_div;
   assign w_last_bit = (r_word_idx == LAST_IDX) && (r_bit_idx == MSB_POS);

   com_config_sclk_tick u_tick (
      .fw_clk_100 (fw_clk_100),
      .fw_rst_n   (fw_rst_n),
      .i_clr      (w_tick_clr),
      .i_enable   (w_tick_en),
      .i_reload   (w_reload),
      .o_tick     (w_tick)
   );

   // Transfer sequencing, before the abort override.
   always_comb begin
      w_run_nxt   = r_state;
      w_run_start = 1'b0;
      w_run_adv   = 1'b0;
      case (r_state)
         IDLE: begin
            if (op_code_w_execute) begin
               w_run_nxt   = SHIFT_LO;
               w_run_start = 1'b1;
            end else begin
               w_run_nxt = IDLE;
            end
         end
         SHIFT_LO: begin
            if (w_tick) begin
               w_run_nxt = SHIFT_HI;
            end else begin
               w_run_nxt = SHIFT_LO;
            end
         end
         SHIFT_HI: begin
            if (w_tick && w_last_bit) begin
               w_run_nxt = LOAD;
            end else if (w_tick) begin
               w_run_nxt = SHIFT_LO;
               w_run_adv = 1'b1;
            end else begin
               w_run_nxt = SHIFT_HI;
            end
         end
         LOAD: begin
            if (w_tick && r_load_half) begin
               w_run_nxt = DONE;
            end else begin
               w_run_nxt = LOAD;
            end
         end
         DONE: begin
            w_run_nxt = IDLE;
         end
         default: begin
            w_run_nxt = IDLE;
         end
      endcase
   end

   // Abort wins over everything, including a coincident start.
   assign w_state_nxt = w_srst ? IDLE : w_run_nxt;
   assign w_start     = w_run_start & ~w_srst;
   assign w_advance   = w_run_adv & ~w_srst;
   assign w_entry_lo  = w_start | w_advance;

   // Word/bit position of the bit about to be presented on sdata.
   always_comb begin
      w_word_nxt = r_word_idx;
      w_bit_nxt  = r_bit_idx;
      if (w_start) begin
         w_word_nxt = {IDX_W{1'b0}};
         w_bit_nxt  = {BIT_W{1'b0}};
      end else if (w_advance) begin
         if (r_bit_idx == MSB_POS) begin
            w_bit_nxt  = {BIT_W{1'b0}};
            w_word_nxt = r_word_idx + IDX_W'(1);
         end else begin
            w_bit_nxt  = r_bit_idx + BIT_W'(1);
         end
      end else begin
         w_word_nxt = r_word_idx;
         w_bit_nxt  = r_bit_idx;
      end
   end

   // The source word is fetched from the live array only at its first bit.
   assign w_sel_eff   = w_start ? array_sel : r_sel;
   assign w_src_word  = w_sel_eff ? config_array_1[w_word_nxt] : config_array_0[w_word_nxt];
   assign w_tx_nxt    = (w_bit_nxt == {BIT_W{1'b0}}) ? w_src_word : r_tx_word;
   assign w_sdata_nxt = w_tx_nxt[MSB_POS - w_bit_nxt];

   // FSM state register.
   always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Capture array select and divider at start.
   always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         r_sel     <= 1'b0;
         r_clk_div <= 8'd0;
      end else if (w_srst) begin
         r_sel     <= 1'b0;
         r_clk_div <= 8'd0;
      end else if (w_start) begin
         r_sel     <= array_sel;
         r_clk_div <= clk_div;
      end else begin
         r_sel     <= r_sel;
         r_clk_div <= r_clk_div;
      end
   end

   // Transmit position, transmit word and serial data; sdata moves only on SHIFT_LO entry.
   always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         r_word_idx <= {IDX_W{1'b0}};
         r_bit_idx  <= {BIT_W{1'b0}};
         r_tx_word  <= {WORD_W{1'b0}};
         r_sdata    <= 1'b0;
      end else if (w_srst) begin
         r_word_idx <= {IDX_W{1'b0}};
         r_bit_idx  <= {BIT_W{1'b0}};
         r_tx_word  <= {WORD_W{1'b0}};
         r_sdata    <= 1'b0;
      end else if (w_entry_lo) begin
         r_word_idx <= w_word_nxt;
         r_bit_idx  <= w_bit_nxt;
         r_tx_word  <= w_tx_nxt;
         r_sdata    <= w_sdata_nxt;
      end else if ((w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI)) begin
         r_sdata    <= r_sdata;
      end else begin
         r_sdata    <= 1'b0;
      end
   end

   // Receive shifter: sdo sampled on the edge that raises sclk.
   always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         r_rx_word <= {WORD_W{1'b0}};
      end else if (w_srst) begin
         r_rx_word <= {WORD_W{1'b0}};
      end else if ((r_state == SHIFT_LO) && w_tick) begin
         r_rx_word <= {r_rx_word[WORD_W-2:0], cfg_sdo};
      end else begin
         r_rx_word <= r_rx_word;
      end
   end

   // LOAD spans two timer periods; this flag marks the second one.
   always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         r_load_half <= 1'b0;
      end else if (w_srst || (r_state != LOAD)) begin
         r_load_half <= 1'b0;
      end else if (w_tick) begin
         r_load_half <= ~r_load_half;
      end else begin
         r_load_half <= r_load_half;
      end
   end

   // Readback store: a word is committed when its last sclk-high phase ends.
   always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         r_readback <= '0;
      end else if (w_srst) begin
         r_readback <= '0;
      end else if ((r_state == SHIFT_HI) && w_tick && (r_bit_idx == MSB_POS)) begin
         r_readback[r_word_idx] <= r_rx_word;
      end else begin
         r_readback <= r_readback;
      end
   end

   // Registered status and strobe outputs aligned with the state register.
   always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         r_sclk <= 1'b0;
         r_load <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (w_srst) begin
         r_sclk <= 1'b0;
         r_load <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_sclk <= (w_state_nxt == SHIFT_HI);
         r_load <= (w_state_nxt == LOAD);
         r_busy <= (w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI) ||
                   (w_state_nxt == LOAD);
         r_done <= (w_state_nxt == DONE);
      end
   end

   assign cfg_sclk       = r_sclk;
   assign cfg_sdata      = r_sdata;
   assign cfg_load       = r_load;
   assign busy           = r_busy;
   assign done           = r_done;
   assign readback_array = r_readback;

endmodule

// File: tb/tb_com_config_array_serializer.sv
// Directed bench for the configuration-array serializer with sdo looped back to sdata.
module tb_com_config_array_serializer;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 op_reset;
   logic                 op_exec;
   logic                 sel;
   logic [7:0]           clk_div;
   logic [255:0][15:0]   cfg0;
   logic [255:0][15:0]   cfg1;
   logic                 sdo;
   logic                 sclk;
   logic                 sdata;
   logic                 load;
   logic                 busy;
   logic                 done;
   logic [255:0][15:0]   rb;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t;

   logic        mon_clr;
   logic        mon_prev_sclk;
   int          mon_rises;
   logic [15:0] mon_first16;
   logic [15:0] mon_last16;
   int          mon_first_rise;
   int          mon_second_rise;
   int          mon_load_cnt;
   int          mon_load_first;
   int          mon_done_cnt;
   int          mon_done_cyc;
   logic        mon_busy_at_done;

   assign sdo = sdata;

   com_config_array_serializer dut (
      .fw_clk_100        (clk),
      .fw_rst_n          (rst_n),
      .op_code_w_reset   (op_reset),
      .op_code_w_execute (op_exec),
      .array_sel         (sel),
      .clk_div           (clk_div),
      .config_array_0    (cfg0),
      .config_array_1    (cfg1),
      .cfg_sdo           (sdo),
      .cfg_sclk          (sclk),
      .cfg_sdata         (sdata),
      .cfg_load          (load),
      .busy              (busy),
      .done              (done),
      .readback_array    (rb)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Mid-cycle monitor of the serial pins.
   always @(negedge clk) begin
      if (mon_clr) begin
         mon_prev_sclk    <= 1'b0;
         mon_rises        <= 0;
         mon_first16      <= 16'h0000;
         mon_last16       <= 16'h0000;
         mon_first_rise   <= 0;
         mon_second_rise  <= 0;
         mon_load_cnt     <= 0;
         mon_load_first   <= 0;
         mon_done_cnt     <= 0;
         mon_done_cyc     <= 0;
         mon_busy_at_done <= 1'b0;
      end else begin
         if (sclk && !mon_prev_sclk) begin
            if (mon_rises < 16) mon_first16 <= {mon_first16[14:0], sdata};
            mon_last16 <= {mon_last16[14:0], sdata};
            if (mon_rises == 0) mon_first_rise <= cyc;
            if (mon_rises == 1) mon_second_rise <= cyc;
            mon_rises <= mon_rises + 1;
         end
         if (load) begin
            if (mon_load_cnt == 0) mon_load_first <= cyc;
            mon_load_cnt <= mon_load_cnt + 1;
         end
         if (done) begin
            mon_done_cnt     <= mon_done_cnt + 1;
            mon_done_cyc     <= cyc;
            mon_busy_at_done <= busy;
         end
         mon_prev_sclk <= sclk;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic goto_cyc(input int target);
      while (cyc < target) step(1);
   endtask

   task automatic start(input logic [7:0] div, input logic s, output int ts);
      clk_div = div;
      sel     = s;
      mon_clr = 1'b1;
      step(1);
      mon_clr = 1'b0;
      op_exec = 1'b1;
      ts      = cyc;
      step(1);
      op_exec = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int k;
      k = 0;
      while (mon_done_cnt == 0 && k < limit) begin
         step(1);
         k++;
      end
      check("done_seen", 64'(mon_done_cnt != 0), 64'd1);
   endtask

   task automatic abort_pulse();
      op_reset = 1'b1;
      step(1);
      op_reset = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      op_reset = 1'b0;
      op_exec  = 1'b0;
      sel      = 1'b0;
      clk_div  = 8'd0;
      cfg0     = '0;
      cfg1     = '0;
      mon_clr  = 1'b1;
      step(3);
      rst_n = 1'b1;
      step(1);
      mon_clr = 1'b0;
      step(100);

      // Reset and idle state.
      check("rst_sclk",  64'(sclk),  64'd0);
      check("rst_sdata", 64'(sdata), 64'd0);
      check("rst_load",  64'(load),  64'd0);
      check("rst_busy",  64'(busy),  64'd0);
      check("rst_done",  64'(done),  64'd0);
      check("rst_rb_zero", 64'(rb == '0), 64'd1);
      check("idle_no_activity", 64'(mon_rises + mon_done_cnt), 64'd0);

      // Transfer A: array 0, H=1.
      cfg0[0] = 16'hA5C3;
      cfg1[0] = 16'hFFFF;
      start(8'd0, 1'b0, t);
      check("A_busy_t1",  64'(busy),  64'd1);
      check("A_sclk_t1",  64'(sclk),  64'd0);
      check("A_sdata_t1", 64'(sdata), 64'd1);
      wait_done(9000);
      check("A_first16",    64'(mon_first16),    64'hA5C3);
      check("A_first_rise", 64'(mon_first_rise), 64'(t + 2));
      check("A_rises",      64'(mon_rises),      64'd4096);
      check("A_load_first", 64'(mon_load_first), 64'(t + 1 + 8192));
      check("A_load_len",   64'(mon_load_cnt),   64'd2);
      check("A_done_cyc",   64'(mon_done_cyc),   64'(t + 1 + 8194));
      check("A_busy_at_done", 64'(mon_busy_at_done), 64'd0);
      check("A_rb0",        64'(rb[0]),          64'hA5C3);
      rb_rest_zero: begin
         logic [255:0][15:0] exp_rb;
         exp_rb    = '0;
         exp_rb[0] = 16'hA5C3;
         check("A_rb_all", 64'(rb === exp_rb), 64'd1);
      end
      step(5);
      check("A_busy_after", 64'(busy), 64'd0);
      check("A_one_done",   64'(mon_done_cnt), 64'd1);

      // Transfer B: array 1, H=4, with live writes during word 0.
      cfg1[0]   = 16'h0000;
      cfg1[255] = 16'h8001;
      start(8'd3, 1'b1, t);
      goto_cyc(t + 10);
      cfg1[0]   = 16'hFFFF;
      cfg1[100] = 16'h1234;
      wait_done(34000);
      check("B_first_rise",  64'(mon_first_rise),  64'(t + 5));
      check("B_sclk_period", 64'(mon_second_rise - mon_first_rise), 64'd8);
      check("B_last16",      64'(mon_last16),      64'h8001);
      check("B_load_first",  64'(mon_load_first),  64'(t + 1 + 32768));
      check("B_load_len",    64'(mon_load_cnt),    64'd8);
      check("B_done_cyc",    64'(mon_done_cyc),    64'(t + 1 + 32776));
      check("B_rb255",       64'(rb[255]),         64'h8001);
      check("B_rb0_late_write",  64'(rb[0]),       64'h0000);
      check("B_rb100_early_write", 64'(rb[100]),   64'h1234);

      // Transfer C: execute re-pulsed mid-transfer with changed inputs.
      cfg0[62] = 16'hFFFF;
      start(8'd0, 1'b0, t);
      goto_cyc(t + 500);
      op_exec = 1'b1;
      clk_div = 8'd5;
      sel     = 1'b1;
      step(1);
      op_exec = 1'b0;
      wait_done(9000);
      check("C_done_cyc", 64'(mon_done_cyc), 64'(t + 1 + 8194));
      step(20);
      check("C_one_done", 64'(mon_done_cnt), 64'd1);
      check("C_rb0",   64'(rb[0]),   64'hA5C3);
      check("C_rb62",  64'(rb[62]),  64'hFFFF);
      check("C_rb255", 64'(rb[255]), 64'h0000);

      // Transfer D: abort at bit 1000 (word 62, all ones).
      start(8'd0, 1'b0, t);
      goto_cyc(t + 2 + 2000);
      check("D_sclk_bit1000",  64'(sclk),  64'd1);
      check("D_sdata_bit1000", 64'(sdata), 64'd1);
      abort_pulse();
      check("D_abort_busy",  64'(busy),  64'd0);
      check("D_abort_sclk",  64'(sclk),  64'd0);
      check("D_abort_sdata", 64'(sdata), 64'd0);
      check("D_abort_load",  64'(load),  64'd0);
      check("D_abort_rb",    64'(rb == '0), 64'd1);
      step(30);
      check("D_no_done", 64'(mon_done_cnt), 64'd0);
      check("D_idle",    64'(busy),         64'd0);

      // Reset coinciding with execute in IDLE: no transfer.
      op_reset = 1'b1;
      op_exec  = 1'b1;
      step(1);
      op_reset = 1'b0;
      op_exec  = 1'b0;
      check("D_coincide_busy", 64'(busy), 64'd0);
      step(3);
      check("D_coincide_busy_later", 64'(busy | sclk), 64'd0);

      // Clean restart from word 0.
      start(8'd0, 1'b0, t);
      goto_cyc(t + 40);
      check("D_restart_first16", 64'(mon_first16),    64'hA5C3);
      check("D_restart_rise",    64'(mon_first_rise), 64'(t + 2));
      abort_pulse();

      // Transfer E: H=256, first two sclk rises, then abort.
      start(8'd255, 1'b0, t);
      goto_cyc(t + 256);
      check("E_sclk_lo_end",  64'(sclk), 64'd0);
      goto_cyc(t + 257);
      check("E_sclk_rise",    64'(sclk), 64'd1);
      goto_cyc(t + 512);
      check("E_sclk_hi_end",  64'(sclk), 64'd1);
      goto_cyc(t + 513);
      check("E_sclk_fall",    64'(sclk), 64'd0);
      goto_cyc(t + 257 + 512 + 5);
      check("E_first_rise",   64'(mon_first_rise),  64'(t + 257));
      check("E_second_rise",  64'(mon_second_rise), 64'(t + 257 + 512));
      abort_pulse();
      check("E_abort_busy",   64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
